bus_fifo_ctrl: RTL and testbench

//  Sequencer and storage directly behind the tri_state bus port of the shared databus.
//  It accepts push/pop commands and drives tri_state's en_write/en_read.
//  A push captures a word from the bus (via tri_state.out) into a circular FIFO.
//  A pop drives the FIFO head onto the bus (via tri_state.in) for one cycle.

---
 rtl/bus_fifo_ctrl.sv | 142 ++++++++++++++
 tb/tb_bus_fifo_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_ctrl.sv
// bus_fifo_ctrl: command sequencer and circular FIFO behind the tri_state bus port.
// Pushes sample the databus through tri_state (en_write) and store the captured word.
// Pops drive the FIFO head onto the databus through tri_state (en_read) for one cycle.
module bus_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic                  cmd_write,
    output logic                  cmd_ready,
    output logic                  en_write,
    output logic                  en_read,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  done,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCount = (ADDR_WIDTH + 1)'(Depth);

    typedef enum logic [1:0] {
        StIdle,
        StCap,
        StLatch,
        StDrive
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  mem_we;

    // Storage is deliberately left out of reset; only the pointers define validity.
    logic [DATA_WIDTH-1:0] mem_q [Depth];

    // State, pointers, occupancy and error pulses; reset wins over any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO write of the word tri_state captured during CAP; suppressed by reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wr_ptr_q] <= bus_in;
        end
    end

    // Next-state, pointer and occupancy update; commands only considered in IDLE.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        mem_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        if (full) begin
                            overflow_d = 1'b1;
                        end else begin
                            state_d = StCap;
                        end
                    end else begin
                        if (empty) begin
                            underflow_d = 1'b1;
                        end else begin
                            state_d = StDrive;
                        end
                    end
                end
            end
            StCap: begin
                // tri_state samples the databus at the end of this cycle.
                state_d = StLatch;
            end
            StLatch: begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
                state_d  = StIdle;
            end
            StDrive: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only, so they are glitch-free toward tri_state.
    always_comb begin
        cmd_ready     = (state_q == StIdle);
        en_write      = (state_q == StCap);
        en_read       = (state_q == StDrive);
        done          = (state_q == StLatch) || (state_q == StDrive);
        bus_out       = (state_q == StDrive) ? mem_q[rd_ptr_q] : '0;
        overflow_err  = overflow_q;
        underflow_err = underflow_q;
        count         = count_q;
        full          = (count_q == DepthCount);
        empty         = (count_q == '0);
    end

    // Bus-direction and occupancy sanity checks for simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(en_write && en_read));
            assert (count_q <= DepthCount);
        end
    end

endmodule

// File: tb/tb_bus_fifo_ctrl.sv
// tb_bus_fifo_ctrl: directed bench for bus_fifo_ctrl with a behavioural tri_state capture.
module tb_bus_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_write;
    logic       cmd_ready;
    logic       en_write;
    logic       en_read;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       done;
    logic       overflow_err;
    logic       underflow_err;
    logic [4:0] count;
    logic       full;
    logic       empty;

    logic [7:0] databus;
    int         vectors;
    int         miscompares;
    bit         mon_en;

    // Observation vectors: {ready_before, c1 flags, c2 flags, ready_after}.
    localparam logic [7:0] PushOk  = 8'b1_100_010_1;
    localparam logic [7:0] PushRej = 8'b1_001_000_1;
    localparam logic [7:0] PopOk   = 8'b1_1100_00_1;
    localparam logic [7:0] PopRej  = 8'b1_0010_00_1;

    bus_fifo_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_write    (cmd_write),
        .cmd_ready    (cmd_ready),
        .en_write     (en_write),
        .en_read      (en_read),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .done         (done),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tri_state model: registered capture of the databus while en_write is high.
    always @(posedge clk) begin
        if (en_write) bus_in <= databus;
    end

    // Bus-direction monitor: never both enables, never an enable while idle.
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if ((en_write && en_read) || (cmd_ready && (en_write || en_read))) begin
                miscompares++;
                $display("FAIL bus_dir: en_write=%b en_read=%b cmd_ready=%b want no overlap",
                         en_write, en_read, cmd_ready);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] d, output logic [7:0] obs);
        logic busy;
        databus   = d;
        cmd_write = 1'b1;
        cmd_valid = 1'b1;
        obs[7]    = cmd_ready;
        step();
        cmd_valid = 1'b0;
        obs[6:4]  = {en_write, done, overflow_err};
        busy      = en_write;
        step();
        obs[3:1]  = {en_write, done, overflow_err};
        if (busy) step();
        obs[0]    = cmd_ready;
    endtask

    task automatic do_pop(output logic [7:0] obs, output logic [7:0] data,
                          output logic [7:0] bus_after);
        cmd_write = 1'b0;
        cmd_valid = 1'b1;
        obs[7]    = cmd_ready;
        step();
        cmd_valid = 1'b0;
        obs[6:3]  = {en_read, done, underflow_err, en_write};
        data      = bus_out;
        step();
        obs[2:1]  = {en_read, underflow_err};
        bus_after = bus_out;
        obs[0]    = cmd_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
        vectors++;
        if ({count, empty, full, cmd_ready} !== {5'd0, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_status: count=%0d empty=%b full=%b ready=%b want 0 1 0 1",
                     count, empty, full, cmd_ready);
        end
        vectors++;
        if ({en_write, en_read, done, overflow_err, underflow_err, bus_out} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: ew=%b er=%b done=%b ovf=%b unf=%b bus_out=%h want 0",
                     en_write, en_read, done, overflow_err, underflow_err, bus_out);
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] obs, data, after;
        do_push(8'hA5, obs);
        vectors++;
        if (obs !== PushOk) begin
            miscompares++;
            $display("FAIL push_a5_seq: got %b want %b", obs, PushOk);
        end
        vectors++;
        if ({count, empty} !== {5'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL push_a5_count: count=%0d empty=%b want 1 0", count, empty);
        end
        do_pop(obs, data, after);
        vectors++;
        if (obs !== PopOk) begin
            miscompares++;
            $display("FAIL pop_a5_seq: got %b want %b", obs, PopOk);
        end
        vectors++;
        if ({data, after} !== {8'hA5, 8'h00}) begin
            miscompares++;
            $display("FAIL pop_a5_data: bus_out=%h then %h want a5 then 00", data, after);
        end
        vectors++;
        if ({count, empty} !== {5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL pop_a5_count: count=%0d empty=%b want 0 1", count, empty);
        end
    endtask

    task automatic test_fill();
        logic [7:0] obs;
        for (int i = 0; i < 16; i++) begin
            do_push(8'(i), obs);
            vectors++;
            if ({obs, count} !== {PushOk, 5'(i + 1)}) begin
                miscompares++;
                $display("FAIL fill_%0d: obs=%b count=%0d want %b %0d", i, obs, count, PushOk,
                         i + 1);
            end
        end
        vectors++;
        if ({full, empty, count} !== {1'b1, 1'b0, 5'd16}) begin
            miscompares++;
            $display("FAIL fill_full: full=%b empty=%b count=%0d want 1 0 16", full, empty, count);
        end
        do_push(8'hEE, obs);
        vectors++;
        if ({obs, count, full} !== {PushRej, 5'd16, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow: obs=%b count=%0d full=%b want %b 16 1", obs, count, full,
                     PushRej);
        end
    endtask

    task automatic test_drain();
        logic [7:0] obs, data, after;
        for (int i = 0; i < 16; i++) begin
            do_pop(obs, data, after);
            vectors++;
            if ({obs, data, after, count} !== {PopOk, 8'(i), 8'h00, 5'(15 - i)}) begin
                miscompares++;
                $display("FAIL drain_%0d: obs=%b data=%h after=%h count=%0d want %b %h 00 %0d",
                         i, obs, data, after, count, PopOk, 8'(i), 15 - i);
            end
        end
        vectors++;
        if ({empty, full} !== 2'b10) begin
            miscompares++;
            $display("FAIL drain_empty: empty=%b full=%b want 1 0", empty, full);
        end
        do_pop(obs, data, after);
        vectors++;
        if ({obs, data, count} !== {PopRej, 8'h00, 5'd0}) begin
            miscompares++;
            $display("FAIL underflow: obs=%b data=%h count=%0d want %b 00 0", obs, data, count,
                     PopRej);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] obs, data, after;
        logic [7:0] q[$];
        logic [7:0] want;
        int         n_push[2] = '{10, 16};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < n_push[r]; i++) begin
                want = 8'(8'h20 + 8'h20 * r + i);
                q.push_back(want);
                do_push(want, obs);
                vectors++;
                if (obs !== PushOk) begin
                    miscompares++;
                    $display("FAIL wrap_push_%0d_%0d: got %b want %b", r, i, obs, PushOk);
                end
            end
            for (int i = 0; i < n_push[r]; i++) begin
                want = q.pop_front();
                do_pop(obs, data, after);
                vectors++;
                if ({obs, data} !== {PopOk, want}) begin
                    miscompares++;
                    $display("FAIL wrap_pop_%0d_%0d: obs=%b data=%h want %b %h", r, i, obs,
                             data, PopOk, want);
                end
            end
            vectors++;
            if ({count, empty} !== {5'd0, 1'b1}) begin
                miscompares++;
                $display("FAIL wrap_count_%0d: count=%0d empty=%b want 0 1", r, count, empty);
            end
        end
    endtask

    task automatic test_midop_reset();
        logic [7:0] obs, data, after;
        for (int i = 0; i < 3; i++) do_push(8'(8'h70 + i), obs);
        vectors++;
        if (count !== 5'd3) begin
            miscompares++;
            $display("FAIL midop_pre_count: count=%0d want 3", count);
        end
        databus   = 8'h99;
        cmd_write = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (en_write !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_in_cap: en_write=%b want 1", en_write);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({count, empty, en_write, done, cmd_ready} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL midop_after: count=%0d empty=%b ew=%b done=%b ready=%b want 0 1 0 0 1",
                     count, empty, en_write, done, cmd_ready);
        end
        step();
        vectors++;
        if ({done, count} !== {1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL midop_no_done: done=%b count=%0d want 0 0", done, count);
        end
        do_pop(obs, data, after);
        vectors++;
        if (obs !== PopRej) begin
            miscompares++;
            $display("FAIL midop_discard: got %b want %b", obs, PopRej);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        databus     = 8'h00;
        bus_in      = 8'h00;
        test_reset();
        test_push_pop();
        test_fill();
        test_drain();
        test_wrap();
        test_midop_reset();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
